addr_sel_exc: RTL and testbench

Parametrised memory-address selector for the multicycle datapath with a built-in exception-vector sequencer. In normal operation it steers one of `NSRC` address sources (PC, ALUOut, …) to the memory address port. On an exception request it latches the cause and the EPC, drives the cause's vector address (`VEC_BASE`+index) to memory, waits for the read, and returns the handler address fetched from the vector byte. It sits between the control unit, the PC/ALUOut registers and the memory address input.

---
 rtl/addr_sel_exc.sv | 167 ++++++++++++++++
 tb/tb_addr_sel_exc.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_sel_exc.sv
// Memory-address selector with an exception-vector sequencer (IDLE -> VEC -> DONE).
// Optional `ADDR_SEL_EXC_PENDING_EN: one-deep pending cause captured while busy.
module addr_sel_exc #(
    parameter int              WIDTH    = 32,
    parameter int              NSRC     = 3,
    parameter int              SELW     = 2,
    parameter longint unsigned VEC_BASE = 253,
    parameter int              NVEC     = 3,
    parameter int              MEM_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src,
    input  logic [NVEC-1:0]       exc_req,
    input  logic [7:0]            mem_byte,
    output logic [WIDTH-1:0]      addr_out,
    output logic                  busy,
    output logic                  exc_done,
    output logic [WIDTH-1:0]      handler_addr,
    output logic [WIDTH-1:0]      epc_out,
    output logic [NVEC-1:0]       cause_out
);

    localparam int CNTW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int IDXW = (NVEC > 1) ? $clog2(NVEC) : 1;

    generate
        if (WIDTH < 64) begin : g_chk
            if (VEC_BASE + NVEC - 1 >= (64'd1 << WIDTH)) begin : g_bad
                $fatal(1, "addr_sel_exc: vector range does not fit in WIDTH");
            end
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, VEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [NVEC-1:0]   cause_q, cause_d;
    logic [WIDTH-1:0]  epc_q, epc_d;
    logic [WIDTH-1:0]  hnd_q, hnd_d;

    logic [WIDTH-1:0]  mux_addr;
    logic [WIDTH-1:0]  vec_addr;
    logic              req_any;
    logic [IDXW-1:0]   req_idx;
    logic              acc;
    logic [IDXW-1:0]   acc_idx;

`ifdef ADDR_SEL_EXC_PENDING_EN
    logic              pend_vld_q, pend_vld_d;
    logic [IDXW-1:0]   pend_idx_q, pend_idx_d;
`endif

    always_comb begin
        mux_addr = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SELW'(i)) mux_addr = src[i*WIDTH +: WIDTH];
        end
    end

    // Descending scan so the lowest set cause is the final assignment.
    always_comb begin
        req_any = |exc_req;
        req_idx = '0;
        for (int i = NVEC - 1; i >= 0; i--) begin
            if (exc_req[i]) req_idx = IDXW'(i);
        end
    end

    assign vec_addr = WIDTH'(VEC_BASE) + WIDTH'(idx_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        hnd_d   = hnd_q;
        acc     = 1'b0;
        acc_idx = req_idx;
`ifdef ADDR_SEL_EXC_PENDING_EN
        pend_vld_d = pend_vld_q;
        pend_idx_d = pend_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_any) acc = 1'b1;
            end
            VEC: begin
`ifdef ADDR_SEL_EXC_PENDING_EN
                if (!pend_vld_q && req_any) begin
                    pend_vld_d = 1'b1;
                    pend_idx_d = req_idx;
                end
`endif
                if (cnt_q == '0) begin
                    hnd_d   = WIDTH'(mem_byte);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef ADDR_SEL_EXC_PENDING_EN
                // A request seen this DONE cycle counts as the pending one.
                if (pend_vld_q) begin
                    acc        = 1'b1;
                    acc_idx    = pend_idx_q;
                    pend_vld_d = 1'b0;
                end else if (req_any) begin
                    acc = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (acc) begin
            state_d = VEC;
            idx_d   = acc_idx;
            cause_d = NVEC'(1) << acc_idx;
            epc_d   = src[WIDTH-1:0];
            cnt_d   = CNTW'(MEM_LAT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cause_q <= '0;
            epc_q   <= '0;
            hnd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            hnd_q   <= hnd_d;
        end
    end

`ifdef ADDR_SEL_EXC_PENDING_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
        end
    end
`endif

    assign busy         = (state_q != IDLE);
    assign exc_done     = (state_q == DONE);
    assign addr_out     = busy ? vec_addr : mux_addr;
    assign handler_addr = hnd_q;
    assign epc_out      = epc_q;
    assign cause_out    = cause_q;

endmodule

// File: tb/tb_addr_sel_exc.sv
// Bench for addr_sel_exc: two instances (MEM_LAT=1 and 3) on shared stimulus,
// compared each cycle against a service-age reference model.
module tb_addr_sel_exc;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic [95:0] src;
    logic [2:0]  exc_req;
    logic [7:0]  mem_byte;

    logic [31:0] o_addr  [2];
    logic [31:0] o_hnd   [2];
    logic [31:0] o_epc   [2];
    logic        o_busy  [2];
    logic        o_done  [2];
    logic [2:0]  o_cause [2];

    always #5 clk = ~clk;

    addr_sel_exc #(.MEM_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .sel(sel), .src(src), .exc_req(exc_req),
        .mem_byte(mem_byte), .addr_out(o_addr[0]), .busy(o_busy[0]),
        .exc_done(o_done[0]), .handler_addr(o_hnd[0]), .epc_out(o_epc[0]),
        .cause_out(o_cause[0]));

    addr_sel_exc #(.MEM_LAT(3)) dut1 (
        .clk(clk), .reset(reset), .sel(sel), .src(src), .exc_req(exc_req),
        .mem_byte(mem_byte), .addr_out(o_addr[1]), .busy(o_busy[1]),
        .exc_done(o_done[1]), .handler_addr(o_hnd[1]), .epc_out(o_epc[1]),
        .cause_out(o_cause[1]));

    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: a service is "age" edges old; data captured at age==lat,
    // done shown while age==lat+1, idle after that.
    bit          m_svc [2];
    int          m_age [2];
    int          m_k   [2];
    logic [31:0] m_hnd [2];
    logic [31:0] m_epc [2];
    logic [2:0]  m_cause [2];
    bit          m_pv  [2];
    int          m_pk  [2];

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int lowest(logic [2:0] r);
        for (int i = 0; i < 3; i++) if (r[i]) return i;
        return 0;
    endfunction

    task automatic model_clear(int d);
        m_svc[d] = 0; m_age[d] = 0; m_k[d] = 0; m_hnd[d] = 0;
        m_epc[d] = 0; m_cause[d] = 0; m_pv[d] = 0; m_pk[d] = 0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) model_clear(d);
    endtask

    task automatic accept(int d, int k);
        m_svc[d]   = 1;
        m_age[d]   = 0;
        m_k[d]     = k;
        m_cause[d] = 3'b001 << k;
        m_epc[d]   = src[31:0];
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) model_clear(d);
            else if (!m_svc[d]) begin
                if (exc_req != 0) accept(d, lowest(exc_req));
            end else if (m_age[d] == lat(d) + 1) begin
                m_svc[d] = 0;
`ifdef ADDR_SEL_EXC_PENDING_EN
                if (m_pv[d]) begin
                    m_pv[d] = 0;
                    accept(d, m_pk[d]);
                end else if (exc_req != 0) accept(d, lowest(exc_req));
`endif
            end else begin
`ifdef ADDR_SEL_EXC_PENDING_EN
                if (!m_pv[d] && exc_req != 0) begin
                    m_pv[d] = 1;
                    m_pk[d] = lowest(exc_req);
                end
`endif
                if (m_age[d] == lat(d)) m_hnd[d] = {24'h0, mem_byte};
                m_age[d]++;
            end
        end
    endtask

    function automatic logic [31:0] exp_addr(int d);
        if (m_svc[d]) return 32'(253 + m_k[d]);
        if (sel < 2'd3) return src[sel*32 +: 32];
        return 32'h0;
    endfunction

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("addr%0d", d),  o_addr[d],  exp_addr(d));
            chk($sformatf("busy%0d", d),  32'(o_busy[d]), 32'(m_svc[d]));
            chk($sformatf("done%0d", d),  32'(o_done[d]),
                32'(m_svc[d] && m_age[d] == lat(d) + 1));
            chk($sformatf("hnd%0d", d),   o_hnd[d],   m_hnd[d]);
            chk($sformatf("epc%0d", d),   o_epc[d],   m_epc[d]);
            chk($sformatf("cause%0d", d), 32'(o_cause[d]), 32'(m_cause[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [4];
    int   nd0, nd1;
    bit   saw255;

    initial begin
        tbl[0] = '{2'd0, 32'h100};
        tbl[1] = '{2'd1, 32'h200};
        tbl[2] = '{2'd2, 32'h300};
        tbl[3] = '{2'd3, 32'h0};

        reset = 1'b1; sel = 0; src = '0; exc_req = 0; mem_byte = 0;
        model_reset();
        idle(2);
        chk("rst_busy", 32'(o_busy[0]), 32'h0);
        chk("rst_hnd",  o_hnd[1], 32'h0);
        reset = 1'b0;

        // Normal mux.
        src = {32'h300, 32'h200, 32'h100};
        foreach (tbl[i]) begin
            sel = tbl[i].sel;
            #1;
            chk($sformatf("mux0_sel%0d", i), o_addr[0], tbl[i].exp);
            chk($sformatf("mux1_sel%0d", i), o_addr[1], tbl[i].exp);
            chk($sformatf("mux_busy%0d", i), 32'(o_busy[0]), 32'h0);
            tick();
        end

        // Overflow, MEM_LAT=1 on dut0.
        sel = 0; src[31:0] = 32'h40; mem_byte = 8'h8C; exc_req = 3'b010;
        tick();
        exc_req = 0;
        chk("ovf_addr_a", o_addr[0], 32'd254);
        chk("ovf_done_a", 32'(o_done[0]), 32'h0);
        tick();
        chk("ovf_addr_b", o_addr[0], 32'd254);
        chk("ovf_done_b", 32'(o_done[0]), 32'h0);
        tick();
        chk("ovf_addr_c", o_addr[0], 32'd254);
        chk("ovf_done_c", 32'(o_done[0]), 32'h1);
        chk("ovf_hnd",    o_hnd[0], 32'h8C);
        chk("ovf_epc",    o_epc[0], 32'h40);
        chk("ovf_cause",  32'(o_cause[0]), 32'h2);
        tick();
        chk("ovf_idle",   32'(o_busy[0]), 32'h0);
        idle(2);

        // Simultaneous causes.
        exc_req = 3'b110;
        tick();
        exc_req = 0;
        chk("sim_addr",  o_addr[0], 32'd254);
        chk("sim_cause", 32'(o_cause[0]), 32'h2);
        idle(5);
        exc_req = 3'b100;
        tick();
        exc_req = 0;
        chk("c2_addr", o_addr[1], 32'd255);
        idle(5);

        // Byte sampling at the last VEC edge.
        mem_byte = 8'h11; exc_req = 3'b001;
        tick();
        exc_req = 0;
        idle(2);
        mem_byte = 8'h22;
        tick();
        mem_byte = 8'h33;
        tick();
        chk("lat3_hnd",  o_hnd[1], 32'h33);
        chk("lat3_done", 32'(o_done[1]), 32'h1);
        chk("lat1_hnd",  o_hnd[0], 32'h11);
        tick();
        chk("lat3_idle", 32'(o_busy[1]), 32'h0);
        idle(1);

        // Reset in the middle of VEC.
        sel = 2'd1; exc_req = 3'b010;
        tick();
        exc_req = 0;
        tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rmid_busy0", 32'(o_busy[0]), 32'h0);
        chk("rmid_busy1", 32'(o_busy[1]), 32'h0);
        chk("rmid_hnd1",  o_hnd[1], 32'h0);
        chk("rmid_addr",  o_addr[1], 32'h200);
        tick();
        reset = 1'b0;
        idle(5);

        // Request during VEC.
        nd0 = 0; nd1 = 0; saw255 = 0;
        exc_req = 3'b001;
        tick();
        exc_req = 3'b100;
        tick();
        exc_req = 0;
        for (int i = 0; i < 11; i++) begin
            nd0 += int'(o_done[0]);
            nd1 += int'(o_done[1]);
            if (o_busy[0] && o_addr[0] == 32'd255) saw255 = 1;
            tick();
        end
`ifdef ADDR_SEL_EXC_PENDING_EN
        chk("pend_ndone0", nd0, 2);
        chk("pend_ndone1", nd1, 2);
        chk("pend_vec255", 32'(saw255), 32'h1);
`else
        chk("pend_ndone0", nd0, 1);
        chk("pend_ndone1", nd1, 1);
        chk("pend_vec255", 32'(saw255), 32'h0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            sel      = 2'($urandom_range(0, 3));
            src      = {$urandom, $urandom, $urandom};
            mem_byte = 8'($urandom);
            exc_req  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
                model_reset();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
